// File: rtl/rr_mux_select.sv
// rr_mux_select: round-robin arbiter producing the registered 3-bit select of
// an 8-input one-hot mux stage. A grant is locked until its transfer ends, is
// aborted, or hits the MAX_BEATS limit; priority then rotates past the holder.
//
// Ports:
//   CLK          rising-edge clock
//   ASYNCRESETN  asynchronous active-low reset
//   req[7:0]     per-source request (bit i -> mux input I<i>)
//   ack          consumer accepts the current beat (beat = valid && ack)
//   last         marks the transferring beat as end of transfer
//   S[2:0]       registered encoded select
//   grant[7:0]   registered one-hot of S while valid, zero otherwise
//   valid        S/grant hold a live selection
//   preempt      one-cycle pulse: grant released by the beat limit
module rr_mux_select #(
    parameter int unsigned MAX_BEATS = 16
) (
    input  logic       CLK,
    input  logic       ASYNCRESETN,
    input  logic [7:0] req,
    input  logic       ack,
    input  logic       last,
    output logic [2:0] S,
    output logic [7:0] grant,
    output logic       valid,
    output logic       preempt
);

    localparam int unsigned NSRC = 8;
    localparam int unsigned PW   = 3;
    localparam int unsigned CW   = 8;
    localparam logic [CW:0] MAX_W = (CW + 1)'(MAX_BEATS);
    localparam logic        LIMIT_EN = (MAX_BEATS != 0);

    typedef enum logic {
        IDLE,
        LOCK
    } state_t;

    state_t          state, state_n;
    logic [PW-1:0]   ptr, ptr_n;
    logic [CW-1:0]   cnt, cnt_n;
    logic [PW-1:0]   s_n;
    logic [NSRC-1:0] grant_n;
    logic            valid_n;
    logic            preempt_n;

    logic [PW-1:0]   arb_ptr;
    logic [PW-1:0]   idx;
    logic [PW-1:0]   win;
    logic            found;
    logic            rel;
    logic            limit_hit;

    // While locked, arbitration already assumes the pointer moved past the holder.
    assign arb_ptr = (state == LOCK) ? (S + PW'(1)) : ptr;

    // First requester at or after arb_ptr, wrapping modulo 8.
    always_comb begin
        found = 1'b0;
        win   = '0;
        idx   = '0;
        for (int k = 0; k < NSRC; k++) begin
            idx = arb_ptr + PW'(k);
            if (!found && req[idx]) begin
                found = 1'b1;
                win   = idx;
            end
        end
    end

    assign limit_hit = LIMIT_EN && (({1'b0, cnt} + (CW + 1)'(1)) == MAX_W);

    // Next-state and output logic.
    always_comb begin
        state_n   = state;
        ptr_n     = ptr;
        cnt_n     = cnt;
        s_n       = S;
        grant_n   = grant;
        valid_n   = valid;
        preempt_n = 1'b0;
        rel       = 1'b0;

        case (state)
            IDLE: begin
                valid_n = 1'b0;
                grant_n = '0;
                if (found) begin
                    s_n     = win;
                    grant_n = NSRC'(1) << win;
                    valid_n = 1'b1;
                    cnt_n   = '0;
                    state_n = LOCK;
                end
            end
            LOCK: begin
                if (!req[S]) begin
                    rel = 1'b1;
                end else if (valid && ack && last) begin
                    rel = 1'b1;
                end else if (valid && ack && limit_hit) begin
                    rel       = 1'b1;
                    preempt_n = 1'b1;
                end else if (valid && ack) begin
                    cnt_n = (cnt == '1) ? cnt : cnt + CW'(1);
                end

                // Hand over with no bubble, or drop to IDLE if nobody asks.
                if (rel) begin
                    ptr_n = S + PW'(1);
                    cnt_n = '0;
                    if (found) begin
                        s_n     = win;
                        grant_n = NSRC'(1) << win;
                        valid_n = 1'b1;
                    end else begin
                        grant_n = '0;
                        valid_n = 1'b0;
                        state_n = IDLE;
                    end
                end
            end
            default: begin
                state_n = IDLE;
                valid_n = 1'b0;
                grant_n = '0;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge CLK or negedge ASYNCRESETN) begin
        if (!ASYNCRESETN) begin
            state   <= IDLE;
            ptr     <= '0;
            cnt     <= '0;
            S       <= '0;
            grant   <= '0;
            valid   <= 1'b0;
            preempt <= 1'b0;
        end else begin
            state   <= state_n;
            ptr     <= ptr_n;
            cnt     <= cnt_n;
            S       <= s_n;
            grant   <= grant_n;
            valid   <= valid_n;
            preempt <= preempt_n;
        end
    end

endmodule

// File: tb/tb_rr_mux_select.sv
// Directed bench for rr_mux_select: a vector table for single-cycle behaviour
// plus hand-written sequences for beat limits and asynchronous reset.
module tb_rr_mux_select;

    logic       CLK;
    logic       ASYNCRESETN;
    logic [7:0] req;
    logic       ack;
    logic       last;

    logic [2:0] s16, s4, s0;
    logic [7:0] g16, g4, g0;
    logic       v16, v4, v0;
    logic       p16, p4, p0;

    int checks   = 0;
    int failures = 0;

    rr_mux_select dut (
        .CLK(CLK), .ASYNCRESETN(ASYNCRESETN), .req(req), .ack(ack), .last(last),
        .S(s16), .grant(g16), .valid(v16), .preempt(p16)
    );

    rr_mux_select #(.MAX_BEATS(4)) dut4 (
        .CLK(CLK), .ASYNCRESETN(ASYNCRESETN), .req(req), .ack(ack), .last(last),
        .S(s4), .grant(g4), .valid(v4), .preempt(p4)
    );

    rr_mux_select #(.MAX_BEATS(0)) dut0 (
        .CLK(CLK), .ASYNCRESETN(ASYNCRESETN), .req(req), .ack(ack), .last(last),
        .S(s0), .grant(g0), .valid(v0), .preempt(p0)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    typedef struct {
        logic       rst;
        logic [7:0] req;
        logic       ack;
        logic       last;
        logic [2:0] s;
        logic [7:0] grant;
        logic       valid;
        logic       preempt;
    } vec_t;

    vec_t vq[$];

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        req  = 8'h00;
        ack  = 1'b0;
        last = 1'b0;
        ASYNCRESETN = 1'b0;
        repeat (2) @(posedge CLK);
        #1;
        ASYNCRESETN = 1'b1;
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic add(input logic r, input logic [7:0] rq, input logic a, input logic l,
                       input logic [2:0] es, input logic [7:0] eg, input logic ev, input logic ep);
        vec_t v;
        v.rst = r; v.req = rq; v.ack = a; v.last = l;
        v.s = es; v.grant = eg; v.valid = ev; v.preempt = ep;
        vq.push_back(v);
    endtask

    initial begin
        ASYNCRESETN = 1'b1;
        req = 8'h00; ack = 1'b0; last = 1'b0;

        // Grant, 3-beat transfer, abort, wrap search, rotation, ignored ack/last.
        add(1, 8'h04, 0, 0, 3'd2, 8'h04, 1, 0);
        add(0, 8'h04, 1, 0, 3'd2, 8'h04, 1, 0);
        add(0, 8'h04, 1, 0, 3'd2, 8'h04, 1, 0);
        add(0, 8'h04, 1, 1, 3'd2, 8'h04, 1, 0);
        add(0, 8'h00, 0, 0, 3'd2, 8'h00, 0, 0);
        add(0, 8'h05, 0, 0, 3'd0, 8'h01, 1, 0);
        add(0, 8'h05, 1, 1, 3'd2, 8'h04, 1, 0);
        add(0, 8'h05, 1, 1, 3'd0, 8'h01, 1, 0);
        add(0, 8'h00, 1, 1, 3'd0, 8'h00, 0, 0);
        add(0, 8'h00, 1, 1, 3'd0, 8'h00, 0, 0);
        add(0, 8'h01, 0, 0, 3'd0, 8'h01, 1, 0);
        add(0, 8'h01, 0, 1, 3'd0, 8'h01, 1, 0);
        add(0, 8'h01, 1, 0, 3'd0, 8'h01, 1, 0);
        // All requesting, single-beat transfers: 0..7,0 with no bubble.
        add(1, 8'hFF, 1, 1, 3'd0, 8'h01, 1, 0);
        for (int k = 1; k <= 8; k++) begin
            logic [2:0] es;
            es = 3'(k % 8);
            add(0, 8'hFF, 1, 1, es, 8'h01 << es, 1, 0);
        end
        // Abort with ack/last in the same cycle, then next grant from ptr=6.
        add(1, 8'h20, 0, 0, 3'd5, 8'h20, 1, 0);
        add(0, 8'h20, 1, 0, 3'd5, 8'h20, 1, 0);
        add(0, 8'h41, 1, 1, 3'd6, 8'h40, 1, 0);
        add(0, 8'h41, 1, 1, 3'd0, 8'h01, 1, 0);

        // Reset state of all instances.
        do_reset();
        check("rst_S",     8'(s16), 8'h00);
        check("rst_grant", g16,     8'h00);
        check("rst_valid", 8'(v16), 8'h00);
        check("rst_pre",   8'(p16), 8'h00);
        check("rst4_valid", 8'(v4), 8'h00);
        check("rst0_valid", 8'(v0), 8'h00);

        foreach (vq[i]) begin
            if (vq[i].rst) do_reset();
            req  = vq[i].req;
            ack  = vq[i].ack;
            last = vq[i].last;
            step();
            check($sformatf("vec%0d_S", i),       8'(s16), 8'(vq[i].s));
            check($sformatf("vec%0d_grant", i),   g16,     vq[i].grant);
            check($sformatf("vec%0d_valid", i),   8'(v16), 8'(vq[i].valid));
            check($sformatf("vec%0d_preempt", i), 8'(p16), 8'(vq[i].preempt));
        end

        // Beat limits: sources 1 and 6 held, ack=1, last=0, 300 beats.
        do_reset();
        req = 8'h42;
        step();
        check("lim_grant_S4",  8'(s4),  8'h01);
        check("lim_grant_S0",  8'(s0),  8'h01);
        check("lim_grant_S16", 8'(s16), 8'h01);
        ack = 1'b1;
        for (int i = 1; i <= 300; i++) begin
            logic [2:0] e4, e16;
            step();
            e4  = ((i / 4) % 2 == 1) ? 3'd6 : 3'd1;
            e16 = ((i / 16) % 2 == 1) ? 3'd6 : 3'd1;
            check($sformatf("lim4_S_b%0d", i),    8'(s4),  8'(e4));
            check($sformatf("lim4_pre_b%0d", i),  8'(p4),  8'((i % 4) == 0));
            check($sformatf("lim16_S_b%0d", i),   8'(s16), 8'(e16));
            check($sformatf("lim16_pre_b%0d", i), 8'(p16), 8'((i % 16) == 0));
            check($sformatf("lim0_S_b%0d", i),    8'(s0),  8'h01);
            check($sformatf("lim0_pre_b%0d", i),  8'(p0),  8'h00);
            check($sformatf("lim0_valid_b%0d", i), 8'(v0), 8'h01);
        end
        ack = 1'b0;
        step();
        check("lim4_pre_clear", 8'(p4), 8'h00);

        // Asynchronous reset mid-transfer on source 7.
        do_reset();
        req = 8'h80;
        step();
        check("ar_grant_S", 8'(s16), 8'h07);
        ack  = 1'b1;
        last = 1'b1;
        ASYNCRESETN = 1'b0;
        #1;
        check("ar_S",     8'(s16), 8'h00);
        check("ar_grant", g16,     8'h00);
        check("ar_valid", 8'(v16), 8'h00);
        ack  = 1'b0;
        last = 1'b0;
        @(negedge CLK);
        ASYNCRESETN = 1'b1;
        step();
        check("ar_regrant_S",     8'(s16), 8'h07);
        check("ar_regrant_grant", g16,     8'h80);
        check("ar_regrant_valid", 8'(v16), 8'h01);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
